mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//   Parametrised multicycle integer multiply/divide unit that produces the Hi/Lo
//   result pair (MULT, MULTU, DIV, DIVU) for the multicycle CPU datapath.
//   Operands come from the A/B register outputs. The Hi/Lo registers load from hi/lo when done=1.
//   Radix-2 iterative: shift-add multiply, restoring divide, one bit per cycle.
// PARAMETERS
//   WIDTH   32   operand width in bits; hi/lo are each WIDTH bits; WIDTH >= 4
//   CNT_W   $clog2(WIDTH)   iteration counter width (derived; do not override)
// PORTS
//   clk       in   1      clock, rising edge
//   reset     in   1      asynchronous reset, active-low (0 = reset)
//   start     in   1      start request; sampled only in IDLE
//   op        in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
//   a         in   WIDTH  multiplicand / dividend; sampled with start
//   b         in   WIDTH  multiplier / divisor; sampled with start
//   busy      out  1      1 in any state other than IDLE
//   done      out  1      single-cycle pulse; hi/lo valid in the same cycle
//   div_zero  out  1      pulses with done when DIV/DIVU has b == 0
//   hi        out  WIDTH  MULT*: upper product half; DIV*: remainder
//   lo        out  WIDTH  MULT*: lower product half; DIV*: quotient
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE; busy, done and div_zero = 0; hi and lo = 0.
//   Reset aborts any operation in flight. No result is produced for it.
// - FSM states: IDLE -> RUN -> FIX -> DONE -> IDLE.
// - IDLE, start=1 at edge E0:
//   - latch |a| and |b| (absolute values for signed ops; raw values for unsigned ops);
//   - latch result signs; load counter = WIDTH-1; go to RUN.
// - RUN: one iteration per cycle. When counter == 0, go to FIX; otherwise decrement.
//   WIDTH RUN cycles in total.
// - FIX: apply signs, one cycle.
//   - MULT: negate the 2*WIDTH product if sign(a) != sign(b).
//   - DIV: negate the quotient if signs differ; the remainder takes the sign of the dividend.
//   - Truncate toward zero.
// - DONE: hi/lo update on the edge entering DONE. done=1 for exactly one cycle, then IDLE.
// - Latency: done is high in the cycle after edge E0+WIDTH+1 (34 cycles for WIDTH=32).
// - Divide by zero (DIV*/b==0) at E0: go directly to DONE.
//   done=1 and div_zero=1 after E0+1; hi/lo keep their previous values.
// - Signed overflow: DIV of -2^(WIDTH-1) by -1 gives lo = 2^(WIDTH-1), hi = 0. No flag.
// - start while busy=1 (including the DONE cycle) is ignored; op/a/b changes mid-run are ignored.
// - hi/lo hold their last result until the next result is written. They change only on entry to DONE.
// - Arithmetic: unsigned internal datapath WIDTH+1 bits for the divide subtract.
//   Product accumulator is 2*WIDTH bits. No truncation before FIX.
// CONFIGURATION
//   MULTDIV_ABORT_EN defined:
//   - adds input port `abort` (1 bit, after op).
//   - abort=1 in RUN or FIX returns to IDLE at the next edge.
//   - done and div_zero stay 0; hi/lo unchanged.
//   - abort in IDLE or DONE has no effect. When abort and start are both high in IDLE, start wins.
//   MULTDIV_ABORT_EN undefined: no abort port; every accepted op runs to DONE.
// TESTING (WIDTH=32)
//   1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001.
//      busy=1 for 34 cycles; done is a 1-cycle pulse on cycle 34.
//   2. MULT a=-3 (0xFFFFFFFD) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; div_zero=0.
//   3. DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
//      DIVU a=7 b=2 -> lo=3 hi=1.
//   4. Prior result hi=1 lo=3, then DIV a=5 b=0 -> done=div_zero=1 one cycle after start.
//      hi=1 and lo=3 stay unchanged.
//   5. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0x00000000.
//   6. Assert reset=0 in RUN cycle 10 -> busy/done/hi/lo=0 immediately.
//      After release, MULTU 6*7 -> lo=42 hi=0. A start pulse mid-run changes nothing.
//      With MULTDIV_ABORT_EN: abort in RUN cycle 5 -> IDLE next edge, no done, hi/lo held.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: radix-2 multicycle MULT/MULTU/DIV/DIVU producing hi/lo.
// Define MULTDIV_ABORT_EN to add an abort input that cancels an op in RUN or FIX.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
`ifdef MULTDIV_ABORT_EN
    input  logic             abort,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;
    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   r_m, r_hi, r_lo;
    logic               r_div, r_neg_q, r_neg_r, r_dz;
    logic               w_abort, w_signed, w_a_neg, w_b_neg, w_dz;
    logic [WIDTH-1:0]   w_a_abs, w_b_abs, w_quot, w_rem, w_neg_quot, w_neg_rem, w_fix_hi, w_fix_lo;
    logic [WIDTH:0]     w_mul_sum, w_shift, w_diff;
    logic [2*WIDTH-1:0] w_mul_p, w_div_p, w_neg_p;
`ifdef MULTDIV_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif
    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & a[WIDTH-1];
    assign w_b_neg  = w_signed & b[WIDTH-1];
    assign w_a_abs  = w_a_neg ? -a : a;
    assign w_b_abs  = w_b_neg ? -b : b;
    assign w_dz     = op[1] && (b == '0);
    // Multiply: shift-add with the multiplier in the low half of r_p
    assign w_mul_sum = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_m} : '0);
    assign w_mul_p   = {w_mul_sum, r_p[WIDTH-1:1]};
    // Divide: restoring; remainder in the high half, quotient shifts into the low half
    assign w_shift = r_p[2*WIDTH-1:WIDTH-1];
    assign w_diff  = w_shift - {1'b0, r_m};
    assign w_div_p = w_diff[WIDTH] ? {r_p[2*WIDTH-2:0], 1'b0}
                                   : {w_diff[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
    assign w_quot     = r_p[WIDTH-1:0];
    assign w_rem      = r_p[2*WIDTH-1:WIDTH];
    assign w_neg_quot = -w_quot;
    assign w_neg_rem  = -w_rem;
    assign w_neg_p    = -r_p;
    assign w_fix_hi = r_div ? (r_neg_r ? w_neg_rem : w_rem)
                            : (r_neg_q ? w_neg_p[2*WIDTH-1:WIDTH] : w_rem);
    assign w_fix_lo = r_div ? (r_neg_q ? w_neg_quot : w_quot)
                            : (r_neg_q ? w_neg_p[WIDTH-1:0] : w_quot);
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: w_next = start ? (w_dz ? S_DONE : S_RUN) : S_IDLE;
            S_RUN:  w_next = w_abort ? S_IDLE : ((r_cnt == '0) ? S_FIX : S_RUN);
            S_FIX:  w_next = w_abort ? S_IDLE : S_DONE;
            S_DONE: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_p     <= '0;
            r_m     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_div   <= op[1];
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                r_dz    <= w_dz;
                r_cnt   <= CNT_W'(WIDTH - 1);
                r_m     <= op[1] ? w_b_abs : w_a_abs;
                r_p     <= {{WIDTH{1'b0}}, op[1] ? w_a_abs : w_b_abs};
            end
            if (r_state == S_RUN) begin
                r_p   <= r_div ? w_div_p : w_mul_p;
                r_cnt <= r_cnt - 1'b1;
            end
            if (r_state == S_FIX && !w_abort) begin
                r_hi <= w_fix_hi;
                r_lo <= w_fix_lo;
            end
        end
    end
    assign busy     = r_state != S_IDLE;
    assign done     = r_state == S_DONE;
    assign div_zero = done && r_dz;
    assign hi       = r_hi;
    assign lo       = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors for mult_div_unit at WIDTH=32.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;
    int          checks = 0, failures = 0, lat = 0, nb = 0;
    logic        poke = 1'b0;
`ifdef MULTDIV_ABORT_EN
    logic        abort = 1'b0;
    int          seen = 0;
`endif
    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
`ifdef MULTDIV_ABORT_EN
        .abort(abort),
`endif
        .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // Called at a negedge; returns at the negedge of the done cycle with lat/nb filled in
    task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = ~o; a = ~x; b = ~y;
        lat = 1; nb = 0;
        for (int i = 0; i < 100; i++) begin
            nb += int'(busy);
            if (done) break;
            if (poke && lat == 5) begin start = 1'b1; op = 2'b10; b = '0; end
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        check("timeout", done, 1);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_zero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        reset = 1'b1;
        @(negedge clk);
        run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulu_hi", hi, 32'hFFFF_FFFE);
        check("mulu_lo", lo, 32'h0000_0001);
        check("mulu_lat", lat, 34);
        check("mulu_busy", nb, 34);
        check("mulu_dz", div_zero, 0);
        @(negedge clk);
        check("pulse_done", done, 0);
        check("pulse_busy", busy, 0);
        run(2'b00, 32'hFFFF_FFFD, 32'd7);
        check("mul_hi", hi, 32'hFFFF_FFFF);
        check("mul_lo", lo, 32'hFFFF_FFEB);
        check("mul_dz", div_zero, 0);
        @(negedge clk);
        run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulnn_hi", hi, 32'h0);
        check("mulnn_lo", lo, 32'h1);
        @(negedge clk);
        run(2'b10, 32'hFFFF_FFF9, 32'd2);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        check("div_lat", lat, 34);
        @(negedge clk);
        run(2'b10, 32'd7, 32'hFFFF_FFFE);
        check("divpn_lo", lo, 32'hFFFF_FFFD);
        check("divpn_hi", hi, 32'h1);
        @(negedge clk);
        run(2'b11, 32'd7, 32'd2);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);
        @(negedge clk);
        run(2'b10, 32'd5, 32'd0);
        check("dz_lat", lat, 1);
        check("dz_flag", div_zero, 1);
        check("dz_hi", hi, 32'd1);
        check("dz_lo", lo, 32'd3);
        @(negedge clk);
        check("dz_end", done, 0);
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0);
        check("ovf_dz", div_zero, 0);
        op = 2'b01; a = 32'd3; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_start", busy, 0);
        op = 2'b01; a = 32'd5; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("run_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        poke = 1'b1;
        run(2'b01, 32'd6, 32'd7);
        poke = 1'b0;
        check("poke_lo", lo, 32'd42);
        check("poke_hi", hi, 32'd0);
        check("poke_lat", lat, 34);
        check("poke_dz", div_zero, 0);
        @(negedge clk);
`ifdef MULTDIV_ABORT_EN
        op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd42);
        for (int i = 0; i < 40; i++) begin
            seen += int'(done);
            @(negedge clk);
        end
        check("abort_nodone", seen, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
